// File: rtl/req_onehot_arbiter.sv
// rtl/req_onehot_arbiter.sv - rising-edge event capture with round-robin one-hot grant
// Feeds the 4-to-2 encoder: grant is one-hot whenever valid=1, so y is always a legal index.
module req_onehot_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         ack,
    input  logic         clr_ovf,
    output logic [N-1:0] grant,
    output logic         valid,
    output logic [N-1:0] pending,
    output logic [N-1:0] overflow
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  req_d_q, req_d_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  overflow_q, overflow_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] pick_q, pick_d;

    logic [N-1:0]  rise;
    logic [N-1:0]  clr;
    logic          found;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] idx_w;
    int            idx;

    always_comb begin
        rise       = req & ~req_d_q;
        clr        = (state_q == GRANT && ack) ? grant_q : '0;
        req_d_d    = req;
        pending_d  = (pending_q & ~clr) | rise;
        // A new edge on an already-pending line is lost work; clr_ovf cannot mask it.
        overflow_d = (clr_ovf ? '0 : overflow_q) | (rise & pending_q & ~clr);
    end

    // Round-robin search over registered pending, starting at ptr and wrapping.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        idx      = 0;
        idx_w    = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = PW'(idx);
            if (!found && pending_q[idx_w]) begin
                found    = 1'b1;
                pick_idx = idx_w;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        pick_d  = pick_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (found) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    pick_d            = pick_idx;
                    state_d           = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    grant_d = '0;
                    state_d = IDLE;
                    ptr_d   = (pick_q == PW'(N - 1)) ? '0 : pick_q + PW'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_d_q    <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
            grant_q    <= '0;
            ptr_q      <= '0;
            pick_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_d_q    <= req_d_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            pick_q     <= pick_d;
        end
    end

    assign grant    = grant_q;
    assign valid    = (state_q == GRANT);
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// tb/tb_req_onehot_arbiter.sv - directed and randomized checks of req_onehot_arbiter
module tb_req_onehot_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic         ack;
    logic         clr_ovf;
    logic [N-1:0] grant;
    logic         valid;
    logic [N-1:0] pending;
    logic [N-1:0] overflow;

    int passed = 0;
    int total  = 0;

    // Event-level reference: pending/overflow sets, pointer, index of outstanding grant.
    logic [N-1:0] m_pend, m_ovf, m_reqd;
    int           m_ptr;
    int           m_gidx;

    wire [12:0] dut_vec = {valid, grant, pending, overflow};

    req_onehot_arbiter #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .ack      (ack),
        .clr_ovf  (clr_ovf),
        .grant    (grant),
        .valid    (valid),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_pend = '0;
        m_ovf  = '0;
        m_reqd = '0;
        m_ptr  = 0;
        m_gidx = -1;
    endtask

    function automatic logic [12:0] m_vec();
        logic [N-1:0] g;
        g = '0;
        if (m_gidx >= 0) g[m_gidx] = 1'b1;
        return {(m_gidx >= 0), g, m_pend, m_ovf};
    endfunction

    task automatic m_update(input logic [N-1:0] r, input logic a, input logic c);
        logic [N-1:0] rise, clr, np, no;
        int nidx;
        rise = r & ~m_reqd;
        clr  = '0;
        if (m_gidx >= 0 && a) clr[m_gidx] = 1'b1;
        np = (m_pend & ~clr) | rise;
        no = (c ? '0 : m_ovf) | (rise & m_pend & ~clr);
        if (m_gidx >= 0) begin
            if (a) begin
                m_ptr  = (m_gidx + 1) % N;
                m_gidx = -1;
            end
        end else begin
            nidx = -1;
            for (int k = N - 1; k >= 0; k--)
                if (m_pend[(m_ptr + k) % N]) nidx = (m_ptr + k) % N;
            m_gidx = nidx;
        end
        m_pend = np;
        m_ovf  = no;
        m_reqd = r;
    endtask

    // Drive inputs after a falling edge, clock once, return at the next falling edge.
    task automatic step(input logic [N-1:0] r, input logic a, input logic c);
        req     = r;
        ack     = a;
        clr_ovf = c;
        @(posedge clk);
        m_update(r, a, c);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 4'b1111; ack = 1'b0; clr_ovf = 1'b0;
        m_reset();
        #3;
        total++;
        if (dut_vec !== 13'd0) $display("FAIL reset_state got=%h want=%h", dut_vec, 13'd0);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, 1'b0, 1'b0);
        total++;
        if (pending !== 4'b1111 || valid !== 1'b0)
            $display("FAIL reset_first_edge pending=%b valid=%b want pending=1111 valid=0", pending, valid);
        else passed++;
        step(4'b1111, 1'b0, 1'b0);
        total++;
        if (grant !== 4'b0001 || valid !== 1'b1 || dut_vec !== m_vec())
            $display("FAIL reset_second_edge got=%h want=%h", dut_vec, m_vec());
        else passed++;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < N; i++) begin
            total++;
            if (grant !== 4'(1 << i) || valid !== 1'b1)
                $display("FAIL rr_grant_%0d grant=%b valid=%b want=%b", i, grant, valid, 4'(1 << i));
            else passed++;
            step(4'b1111, 1'b1, 1'b0);
            total++;
            if (valid !== 1'b0 || grant !== 4'b0000 || dut_vec !== m_vec())
                $display("FAIL rr_gap_%0d got=%h want=%h", i, dut_vec, m_vec());
            else passed++;
            if (i < N - 1) step(4'b1111, 1'b0, 1'b0);
        end
        total++;
        if (pending !== 4'b0000) $display("FAIL rr_drained pending=%b want=0000", pending);
        else passed++;
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        total++;
        if (grant !== 4'b0001) $display("FAIL rr_ptr_wrap grant=%b want=0001", grant);
        else passed++;
        step(4'b0011, 1'b1, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        step(4'b0011, 1'b1, 1'b0);
        total++;
        if (dut_vec !== m_vec() || pending !== 4'b0000)
            $display("FAIL rr_idle got=%h want=%h", dut_vec, m_vec());
        else passed++;
    endtask

    task automatic test_fairness();
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        total++;
        if (grant !== 4'b0010) $display("FAIL fair_first grant=%b want=0010", grant);
        else passed++;
        step(4'b1011, 1'b0, 1'b0);
        step(4'b1011, 1'b1, 1'b0);
        total++;
        if (pending !== 4'b1001) $display("FAIL fair_pending pending=%b want=1001", pending);
        else passed++;
        step(4'b1011, 1'b0, 1'b0);
        total++;
        if (grant !== 4'b1000) $display("FAIL fair_after_ptr2 grant=%b want=1000", grant);
        else passed++;
        step(4'b1011, 1'b1, 1'b0);
        step(4'b1011, 1'b0, 1'b0);
        total++;
        if (grant !== 4'b0001) $display("FAIL fair_wrap grant=%b want=0001", grant);
        else passed++;
        step(4'b1011, 1'b1, 1'b0);
        total++;
        if (dut_vec !== m_vec()) $display("FAIL fair_end got=%h want=%h", dut_vec, m_vec());
        else passed++;
    endtask

    task automatic test_overflow();
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        total++;
        if (pending !== 4'b0100 || overflow !== 4'b0100)
            $display("FAIL ovf_set pending=%b overflow=%b want 0100/0100", pending, overflow);
        else passed++;
        step(4'b0100, 1'b0, 1'b1);
        total++;
        if (overflow !== 4'b0000 || pending !== 4'b0100)
            $display("FAIL ovf_clear pending=%b overflow=%b want 0100/0000", pending, overflow);
        else passed++;
        step(4'b0100, 1'b1, 1'b0);
        total++;
        if (dut_vec !== m_vec()) $display("FAIL ovf_end got=%h want=%h", dut_vec, m_vec());
        else passed++;
    endtask

    task automatic test_collide();
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        total++;
        if (grant !== 4'b0001) $display("FAIL coll_granted grant=%b want=0001", grant);
        else passed++;
        step(4'b0001, 1'b1, 1'b0);
        total++;
        if (pending !== 4'b0001 || overflow !== 4'b0000 || valid !== 1'b0)
            $display("FAIL coll_keep pending=%b overflow=%b valid=%b want 0001/0000/0", pending, overflow, valid);
        else passed++;
        step(4'b0001, 1'b0, 1'b0);
        total++;
        if (grant !== 4'b0001 || valid !== 1'b1)
            $display("FAIL coll_regrant grant=%b valid=%b want 0001/1", grant, valid);
        else passed++;
        step(4'b0001, 1'b1, 1'b0);
    endtask

    task automatic test_mid_reset();
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b1010, 1'b0, 1'b0);
        step(4'b1010, 1'b0, 1'b0);
        total++;
        if (grant !== 4'b1000 || valid !== 1'b1)
            $display("FAIL mrst_pre grant=%b valid=%b want 1000/1", grant, valid);
        else passed++;
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        total++;
        if (dut_vec !== 13'd0) $display("FAIL mrst_async got=%h want=%h", dut_vec, 13'd0);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1010, 1'b0, 1'b0);
        step(4'b1010, 1'b0, 1'b0);
        total++;
        if (grant !== 4'b0010 || dut_vec !== m_vec())
            $display("FAIL mrst_restart got=%h want=%h", dut_vec, m_vec());
        else passed++;
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic a, c;
        for (int i = 0; i < 400; i++) begin
            r = 4'($urandom);
            a = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 9) == 0);
            step(r, a, c);
            total++;
            if (dut_vec !== m_vec())
                $display("FAIL random_cycle_%0d got=%h want=%h", i, dut_vec, m_vec());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fairness();
        test_overflow();
        test_collide();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
